// File: rtl/led_blink_sched.sv
// rtl/led_blink_sched.sv - fixed-priority status LED blink-code sequencer
// Optional idle heartbeat on the LED when LED_HEARTBEAT_EN is defined.
module led_blink_sched #(
    parameter int NUM_REQ   = 4,
    parameter int TICK_DIV  = 10_000_000,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 3,
    parameter int GAP_TICKS = 10,
    parameter int HB_TICKS  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [4*NUM_REQ-1:0]   req_code,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   done,
    output logic                   led
);

    localparam int MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAX_B = (GAP_TICKS > HB_TICKS) ? GAP_TICKS : HB_TICKS;
    localparam int T_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int PW    = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_TICKS - 1);
    localparam logic [TW-1:0] HB_LAST  = TW'(HB_TICKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]         state;
    logic [PW-1:0]      presc;
    logic [TW-1:0]      tcnt;
    logic [3:0]         pcnt;
    logic [TW-1:0]      limit;
    logic               tick;
    logic               phase_last;
    logic               start;
    logic               run_cnt;
    logic               any_elig;
    logic [NUM_REQ-1:0] win_oh;
    logic [3:0]         win_code;

    assign tick       = (presc == PS_LAST);
    assign phase_last = tick && (tcnt == limit);

    // The done cycle is spent in IDLE without sampling, so the next grant is two cycles later.
    assign start = (state == S_IDLE) && !done && any_elig;

    always_comb begin
        limit = HB_LAST;
        case (state)
            S_ON:    limit = ON_LAST;
            S_OFF:   limit = OFF_LAST;
            S_GAP:   limit = GAP_LAST;
            default: limit = HB_LAST;
        endcase
    end

    always_comb begin
        any_elig = 1'b0;
        win_oh   = '0;
        win_code = 4'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (req_code[4*i +: 4] != 4'd0) && !any_elig) begin
                any_elig  = 1'b1;
                win_oh[i] = 1'b1;
                win_code  = req_code[4*i +: 4];
            end
        end
    end

`ifdef LED_HEARTBEAT_EN
    assign run_cnt = 1'b1;
`else
    assign run_cnt = (state != S_IDLE);
`endif

    // Prescaler and tick counter restart on grant and on every phase boundary.
    always_ff @(posedge clk) begin
        if (reset || start || phase_last) begin
            presc <= '0;
            tcnt  <= '0;
        end else if (run_cnt) begin
            if (tick) begin
                presc <= '0;
                tcnt  <= tcnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            led   <= 1'b0;
            pcnt  <= 4'd0;
        end else begin
            grant <= '0;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        grant <= win_oh;
                        busy  <= 1'b1;
                        led   <= 1'b1;
                        pcnt  <= win_code;
                        state <= S_ON;
                    end else begin
                        busy <= 1'b0;
`ifdef LED_HEARTBEAT_EN
                        if (phase_last) begin
                            led <= ~led;
                        end
`else
                        led <= 1'b0;
`endif
                    end
                end
                S_ON: begin
                    if (phase_last) begin
                        state <= S_OFF;
                        led   <= 1'b0;
                        pcnt  <= pcnt - 4'd1;
                    end
                end
                S_OFF: begin
                    if (phase_last) begin
                        if (pcnt != 4'd0) begin
                            state <= S_ON;
                            led   <= 1'b1;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (phase_last) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                        led   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    led   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_blink_sched.sv
// tb/tb_led_blink_sched.sv - directed vector bench for led_blink_sched
module tb_led_blink_sched;

    localparam int TD   = 4;
    localparam int ON   = 2;
    localparam int OFF  = 3;
    localparam int GAP  = 5;
    localparam int HB   = 3;
    localparam int NREQ = 4;

    localparam int ON_C  = ON * TD;
    localparam int PER_C = (ON + OFF) * TD;
    localparam int GAP_C = GAP * TD;
    localparam int HB_C  = HB * TD;

    logic            clk;
    logic            reset;
    logic [NREQ-1:0] req;
    logic [15:0]     req_code;
    logic [NREQ-1:0] grant;
    logic            busy;
    logic            done;
    logic            led;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] code;
        logic [3:0]  exp_grant;
    } vec_t;

    vec_t vecs[7];

    led_blink_sched #(
        .NUM_REQ  (NREQ),
        .TICK_DIV (TD),
        .ON_TICKS (ON),
        .OFF_TICKS(OFF),
        .GAP_TICKS(GAP),
        .HB_TICKS (HB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .req_code(req_code),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at the grant cycle; walks to the cycle after done comparing every cycle to the model.
    task automatic trace(input int code, input logic [3:0] exp_g, input string nm,
                         input int chg_at, input logic [15:0] chg_code);
        int t_done;
        int bad;
        int first_done;
        int busy_n;
        logic el;
        t_done     = code * PER_C + GAP_C;
        bad        = 0;
        first_done = -1;
        busy_n     = 0;
        for (int k = 0; k <= t_done; k++) begin
            el = (k < code * PER_C) && ((k % PER_C) < ON_C);
            if (led !== el) bad++;
            if (busy) busy_n++;
            if (done === 1'b1 && first_done < 0) first_done = k;
            if (done !== (k == t_done)) bad++;
            if (grant !== ((k == 0) ? exp_g : 4'b0000)) bad++;
            if (k == chg_at) req_code = chg_code;
            @(negedge clk);
        end
        if (busy) busy_n++;
        chk({nm, "_trace"}, bad, 0);
        chk({nm, "_done_at"}, first_done, t_done);
        chk({nm, "_busy_len"}, busy_n, t_done + 1);
        chk({nm, "_after_done"}, {busy, done, grant}, 0);
    endtask

    initial begin
        int bad;
        reset    = 1'b1;
        req      = '0;
        req_code = '0;

        vecs[0] = '{4'b0001, 16'h0003, 4'b0001};
        vecs[1] = '{4'b0110, 16'h0210, 4'b0010};
        vecs[2] = '{4'b1000, 16'h0000, 4'b0000};
        vecs[3] = '{4'b1111, 16'h5550, 4'b0010};
        vecs[4] = '{4'b1100, 16'h7700, 4'b0100};
        vecs[5] = '{4'b0000, 16'hFFFF, 4'b0000};
        vecs[6] = '{4'b1001, 16'hF000, 4'b1000};

        do_reset();
        chk("reset_grant", grant, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_led", led, 0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            req      = vecs[v].req;
            req_code = vecs[v].code;
            @(negedge clk);
            chk($sformatf("arb%0d_grant", v), grant, vecs[v].exp_grant);
            chk($sformatf("arb%0d_busy", v), busy, (vecs[v].exp_grant != 0));
            chk($sformatf("arb%0d_led", v), led, (vecs[v].exp_grant != 0));
            req = '0;
        end

        do_reset();
        req      = 4'b0001;
        req_code = 16'h0003;
        @(negedge clk);
        req = '0;
        trace(3, 4'b0001, "single", -1, 16'h0);

        do_reset();
        req      = 4'b0110;
        req_code = 16'h0210;
        @(negedge clk);
        req = 4'b0100;
        trace(1, 4'b0010, "simul_a", -1, 16'h0);
        @(negedge clk);
        req = '0;
        trace(2, 4'b0100, "simul_b", -1, 16'h0);

        do_reset();
        req      = 4'b1000;
        req_code = 16'h0000;
        bad      = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (grant !== 4'b0000 || busy !== 1'b0) bad++;
`ifndef LED_HEARTBEAT_EN
            if (led !== 1'b0) bad++;
`endif
        end
        chk("zero_code", bad, 0);
        req = '0;

        do_reset();
        req      = 4'b0001;
        req_code = 16'h0003;
        @(negedge clk);
        req = '0;
        repeat (22) @(negedge clk);
        chk("midrst_led_before", led, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_outputs", {led, busy, done, grant}, 0);
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("midrst_no_done", bad, 0);
        req      = 4'b0001;
        req_code = 16'h0001;
        @(negedge clk);
        req = '0;
        trace(1, 4'b0001, "midrst_new", -1, 16'h0);

        do_reset();
        req      = 4'b0001;
        req_code = 16'h0002;
        @(negedge clk);
        req = '0;
        trace(2, 4'b0001, "codechg", 5, 16'h0009);

`ifdef LED_HEARTBEAT_EN
        do_reset();
        bad = 0;
        for (int j = 0; j < 74; j++) begin
            if (led !== (((j / HB_C) % 2) == 1)) bad++;
            @(negedge clk);
        end
        chk("hb_toggle", bad, 0);
        chk("hb_led_low_before_req", led, 0);
        req      = 4'b0001;
        req_code = 16'h0001;
        @(negedge clk);
        req = '0;
        trace(1, 4'b0001, "hb_grant", -1, 16'h0);
        bad = 0;
        for (int m = 1; m <= HB_C + 1; m++) begin
            if (led !== (m >= HB_C)) bad++;
            @(negedge clk);
        end
        chk("hb_restart", bad, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/led_blink_sched.md
Name: led_blink_sched

Overview:
- Sequencer and arbiter for the single board status LED, 100 MHz `clk` domain.
- Shares the LED among NUM_REQ requesters; each requester presents a blink code of 1..15 pulses.
- Arbitrates with fixed priority, plays the winner's code as timed on/off pulses, then holds a closing gap before taking the next request.
- Replaces ad-hoc per-design LED toggling in the top level.

Parameters:
- NUM_REQ, 4, number of requesters (1..8).
- TICK_DIV, 10_000_000, clk cycles per tick (100 ms at 100 MHz); minimum 2.
- ON_TICKS, 2, ticks LED is high per pulse (minimum 1).
- OFF_TICKS, 3, ticks LED is low after each pulse (minimum 1).
- GAP_TICKS, 10, extra low ticks after the final pulse's OFF phase (minimum 1).
- HB_TICKS, 5, heartbeat half-period in ticks; used only with the optional feature.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request, bit i = requester i.
- req_code  in  4*NUM_REQ  blink count; requester i uses bits [4i+3:4i]; 0 is invalid.
- grant  out  NUM_REQ  one-hot, one-cycle pulse when a request is accepted.
- busy  out  1  high from grant until done, inclusive.
- done  out  1  one-cycle pulse at the end of GAP.
- led  out  1  registered LED drive.

Behaviour:
- One clock; reset is synchronous and active-high; all outputs are registered.
- Reset values: grant=0, busy=0, done=0, led=0, state=IDLE, prescaler=0, tick count=0, pulse count=0.
- Reset wins over every other event, including mid-sequence. Outputs take reset values at the next edge; any in-flight code is discarded and not resumed.
- Prescaler:
  - Counts 0..TICK_DIV-1 and asserts tick internally when at TICK_DIV-1.
  - Cleared at grant and at every state transition, so phase timing is exact.
- Eligibility and arbitration:
  - Requester i is eligible when req[i]=1 and its code != 0.
  - Requests with code 0 are ignored: no grant, no state change.
  - Lowest eligible index wins. Requests are sampled only in IDLE.
- States:
  - IDLE: if any requester is eligible at edge N, then at N+1: grant[w]=1 for exactly one cycle, busy=1, led=1, pulse count = code[w], state=ON. Otherwise led=0 (see Optional Feature) and busy=0.
  - ON: led=1 for exactly ON_TICKS*TICK_DIV cycles. Then state=OFF, led=0, and pulse count decrements by 1.
  - OFF: led=0 for OFF_TICKS*TICK_DIV cycles. Then, if pulse count != 0: state=ON, led=1. Otherwise state=GAP.
  - GAP: led=0 for GAP_TICKS*TICK_DIV cycles. Then done=1 for one cycle and state=IDLE.
- busy deasserts on the cycle after done. The earliest next grant is 2 cycles after done: one cycle in IDLE to sample, then grant.
- Code is latched at grant. Later changes to req or req_code have no effect until IDLE.
- A requester still holding req after its grant is re-arbitrated in the next IDLE. Higher priority can starve lower; that is accepted behaviour.
- Width rules:
  - Pulse count is 4 bits.
  - Tick counter is wide enough for max(ON_TICKS, OFF_TICKS, GAP_TICKS, HB_TICKS).
  - Prescaler is $clog2(TICK_DIV) bits.
  - No wrap-around is permitted; counters compare against the limit minus 1.
- Total busy length, from the grant cycle to the done cycle inclusive: code*(ON_TICKS+OFF_TICKS)*TICK_DIV + GAP_TICKS*TICK_DIV + 1 cycles.

Optional Feature:
- Macro: LED_HEARTBEAT_EN.
- Defined:
  - In IDLE with no eligible request, led toggles every HB_TICKS*TICK_DIV cycles, using the tick counter free-running in IDLE.
  - Heartbeat state is cleared on grant; led is forced to 1 at grant regardless of heartbeat phase.
  - On return to IDLE, led starts at 0 and the first toggle comes HB_TICKS*TICK_DIV cycles later.
- Undefined: led=0 throughout IDLE, and heartbeat logic is not synthesized.

Test Plan:
(Test plan uses TICK_DIV=4, ON_TICKS=2, OFF_TICKS=3, GAP_TICKS=5, HB_TICKS=3, NUM_REQ=4.)
- Single request: req=4'b0001, code0=3, held 1 cycle in IDLE.
  - Expected: grant=4'b0001 one cycle later.
  - Expected led: high 8 cycles, low 12, high 8, low 12, high 8, low 12+20.
  - Expected: done pulse exactly 80 cycles after grant; busy high 81 cycles.
- Simultaneous requests: req=4'b0110, code1=1, code2=2.
  - Expected: grant=4'b0010 first; one pulse; done after 40 cycles.
  - Expected: with req[2] still held, grant=4'b0100 2 cycles after done; two pulses.
- Zero code: req=4'b1000, code3=0 held 50 cycles.
  - Expected: no grant, busy=0, led=0 (feature off).
- Reset mid-sequence: assert reset for 1 cycle during the second ON phase of a code-3 sequence.
  - Expected: next cycle led=0, busy=0, grant=0, done never pulses.
  - Expected: a new request afterwards is granted normally with correct timing.
- Code changes after grant: change req_code 5 cycles after grant.
  - Expected: pulse count unchanged from the latched value.
- LED_HEARTBEAT_EN defined, idle, no requests.
  - Expected: led toggles every 12 cycles.
  - Expected: a request arriving while led=0 still yields led=1 on the grant cycle.
